hazard_sched: RTL and testbench

- Pipeline scheduler for the 5-stage RISC-V core.
- Keeps its own shadow of the EX, MEM and WB stage control fields (rd, RegWrite, ResultSrc, memory access, EX rs1/rs2), sourced from the main decoder outputs in decode.
- Produces forwarding selects, load-use stalls, branch/jump flushes, and a global freeze while the data memory is not ready.
- Sits beside the control unit; drives the enables and clears of all pipeline registers.

---
 rtl/hazard_pkg.sv | 53 +++++
 rtl/hazard_mem_wait.sv | 64 ++++++
 rtl/hazard_sched.sv | 141 ++++++++++++++
 tb/tb_hazard_sched.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard scheduler.
// Holds forwarding select codes, the load ResultSrc encoding, the EX/MEM/WB
// shadow entry layouts, the memory-wait FSM state type and the forwarding
// select helper.
package hazard_pkg;

   localparam int unsigned REG_W = 5;

   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [1:0] RESULTSRC_MEM = 2'b01;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic [1:0]       resultsrc;
      logic             memacc;
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
   } ex_shadow_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
      logic [1:0]       resultsrc;
      logic             memacc;
   } mem_shadow_t;

   typedef struct packed {
      logic             valid;
      logic [REG_W-1:0] rd;
      logic             regwrite;
   } wb_shadow_t;

   typedef enum logic {
      MW_IDLE = 1'b0,
      MW_WAIT = 1'b1
   } mem_state_e;

   // MEM beats WB; x0 is never forwarded.
   function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] rs,
                                          input mem_shadow_t       m,
                                          input wb_shadow_t        w);
      if (m.valid && m.regwrite && (m.rd != '0) && (m.rd == rs)) return FWD_MEM;
      if (w.valid && w.regwrite && (w.rd != '0) && (w.rd == rs)) return FWD_WB;
      return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_mem_wait.sv
// Data-memory wait tracker: IDLE/WAIT FSM, saturating wait counter and the
// sticky timeout flag.
// Ports: clk, rst_n (async active-low), mem_wait_i (MEM access not done this
// cycle), dmem_ready_i, mem_err_o (sticky, registered).
// The counter counts every cycle of a continuous wait, including the cycle
// that enters WAIT, so mem_err rises after MEM_TIMEOUT waiting cycles.
module hazard_mem_wait
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic mem_wait_i,
   input  logic dmem_ready_i,
   output logic mem_err_o
);

   localparam int unsigned      CNT_W   = 8;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

   mem_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   // Next state, counter and sticky error
   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      err_d   = err_q;
      case (state_q)
         MW_IDLE: begin
            if (mem_wait_i) begin
               state_d = MW_WAIT;
               cnt_d   = CNT_W'(1);
            end
         end
         MW_WAIT: begin
            if (dmem_ready_i) begin
               state_d = MW_IDLE;
            end else begin
               cnt_d = (cnt_q >= CNT_MAX) ? CNT_MAX : cnt_q + CNT_W'(1);
            end
         end
         default: state_d = MW_IDLE;
      endcase
      if (cnt_d == CNT_MAX) err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= MW_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign mem_err_o = err_q;

endmodule

// File: rtl/hazard_sched.sv
// Pipeline scheduler for the 5-stage RISC-V core.
// Keeps shadow copies of the EX/MEM/WB control fields and drives stall,
// flush and forwarding controls for the pipeline registers.
// Ports: clk, rst (async active-low), decode fields (valid_d, rs1_d, rs2_d,
// rd_d, regwrite_d, resultsrc_d, memwrite_d), pcsrc_e, dmem_ready;
// outputs stall_f..stall_w, flush_d, flush_e, forward_a_e, forward_b_e,
// mem_err. Stall/flush/forward outputs are combinational.
// Build option HAZ_PERF_CNT_EN adds stall_cycles and flush_count counters.
module hazard_sched
   import hazard_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned REG_AW      = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_d,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rd_d,
   input  logic              regwrite_d,
   input  logic [1:0]        resultsrc_d,
   input  logic              memwrite_d,
   input  logic              pcsrc_e,
   input  logic              dmem_ready,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              stall_w,
   output logic              flush_d,
   output logic              flush_e,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
`ifdef HAZ_PERF_CNT_EN
   output logic [31:0]       stall_cycles,
   output logic [31:0]       flush_count,
`endif
   output logic              mem_err
);

   ex_shadow_t  e_q, e_d;
   mem_shadow_t m_q, m_d;
   wb_shadow_t  w_q, w_d;
   logic        mem_wait;
   logic        load_use;
   logic        unused_m_resultsrc;

   // MEM ResultSrc is carried for visibility; nothing downstream needs it
   assign unused_m_resultsrc = ^m_q.resultsrc;

   assign mem_wait = m_q.valid & m_q.memacc & ~dmem_ready;

   assign load_use = e_q.valid & e_q.regwrite & (e_q.resultsrc == RESULTSRC_MEM) &
                     (e_q.rd != '0) &
                     ((e_q.rd == REG_W'(rs1_d)) | (e_q.rd == REG_W'(rs2_d)));

   // Priority: memory freeze > redirect flush > load-use bubble > advance
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      stall_w = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      e_d     = e_q;
      m_d     = m_q;
      w_d     = w_q;
      if (mem_wait) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
         stall_w = 1'b1;
      end else begin
         w_d = '{valid: m_q.valid, rd: m_q.rd, regwrite: m_q.regwrite};
         m_d = '{valid: e_q.valid, rd: e_q.rd, regwrite: e_q.regwrite,
                 resultsrc: e_q.resultsrc, memacc: e_q.memacc};
         if (pcsrc_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            e_d     = '0;
         end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
            e_d     = '0;
         end else begin
            e_d = '{valid: valid_d, rd: REG_W'(rd_d), regwrite: regwrite_d,
                    resultsrc: resultsrc_d,
                    memacc: (resultsrc_d == RESULTSRC_MEM) | memwrite_d,
                    rs1: REG_W'(rs1_d), rs2: REG_W'(rs2_d)};
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         e_q <= e_d;
         m_q <= m_d;
         w_q <= w_d;
      end
   end

   assign forward_a_e = fwd_sel(e_q.rs1, m_q, w_q);
   assign forward_b_e = fwd_sel(e_q.rs2, m_q, w_q);

   hazard_mem_wait #(
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) u_mem_wait (
      .clk          (clk),
      .rst_n        (rst),
      .mem_wait_i   (mem_wait),
      .dmem_ready_i (dmem_ready),
      .mem_err_o    (mem_err)
   );

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt_q, flush_cnt_q;

   // Free-running event counters, wrapping modulo 2^32
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         if (stall_d) stall_cnt_q <= stall_cnt_q + 32'd1;
         if (flush_d) flush_cnt_q <= flush_cnt_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cnt_q;
   assign flush_count  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Self-checking bench for hazard_sched: an instruction-level pipeline model
// produces the expected controls for each cycle into a queue; a monitor on
// the falling edge pops and compares against the DUT.
module tb_hazard_sched;

   localparam int TO = 16;

   logic       clk;
   logic       rst;
   logic       valid_d;
   logic [4:0] rs1_d, rs2_d, rd_d;
   logic       regwrite_d;
   logic [1:0] resultsrc_d;
   logic       memwrite_d;
   logic       pcsrc_e;
   logic       dmem_ready;
   logic       stall_f, stall_d, stall_e, stall_m, stall_w;
   logic       flush_d, flush_e;
   logic [1:0] forward_a_e, forward_b_e;
   logic       mem_err;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cycles, flush_count;
`endif

   hazard_sched #(.MEM_TIMEOUT(TO), .REG_AW(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .valid_d     (valid_d),
      .rs1_d       (rs1_d),
      .rs2_d       (rs2_d),
      .rd_d        (rd_d),
      .regwrite_d  (regwrite_d),
      .resultsrc_d (resultsrc_d),
      .memwrite_d  (memwrite_d),
      .pcsrc_e     (pcsrc_e),
      .dmem_ready  (dmem_ready),
      .stall_f     (stall_f),
      .stall_d     (stall_d),
      .stall_e     (stall_e),
      .stall_m     (stall_m),
      .stall_w     (stall_w),
      .flush_d     (flush_d),
      .flush_e     (flush_e),
      .forward_a_e (forward_a_e),
      .forward_b_e (forward_b_e),
`ifdef HAZ_PERF_CNT_EN
      .stall_cycles(stall_cycles),
      .flush_count (flush_count),
`endif
      .mem_err     (mem_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit valid;
      int rd, rs1, rs2;
      bit rw, ld, mw;
   } instr_t;

   typedef struct {
      bit        sf, sd, se, sm, sw, fd, fe;
      int        fa, fb;
      bit        err;
      bit [31:0] sc, fc;
   } exp_t;

   exp_t      q[$];
   instr_t    ex, mm, wb;
   int        waitrun;
   bit        err_m;
   bit [31:0] sc_m, fc_m;
   bit        last_sd, last_mw;
   int        checks   = 0;
   int        failures = 0;

   function automatic instr_t mk(bit v, int rd, int rs1, int rs2, bit rw, bit ld, bit mw);
      instr_t i;
      i.valid = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2;
      i.rw = rw; i.ld = ld; i.mw = mw;
      return i;
   endfunction

   function automatic instr_t nop();
      return mk(0, 0, 0, 0, 0, 0, 0);
   endfunction

   function automatic int pick_reg();
      if ($urandom_range(0, 4) == 0) return int'($urandom_range(0, 31));
      return int'($urandom_range(0, 3));
   endfunction

   function automatic instr_t rnd();
      instr_t i;
      i.valid = ($urandom_range(0, 7) != 0);
      i.rd    = pick_reg();
      i.rs1   = pick_reg();
      i.rs2   = pick_reg();
      i.ld    = ($urandom_range(0, 3) == 0);
      i.mw    = !i.ld && ($urandom_range(0, 5) == 0);
      i.rw    = i.ld ? 1'b1 : (i.mw ? 1'b0 : ($urandom_range(0, 4) != 0));
      return i;
   endfunction

   // Youngest older in-flight writer of rs wins: MEM=2, WB=1, none=0
   function automatic int fwd(int rs);
      instr_t older[2];
      older[0] = mm;
      older[1] = wb;
      for (int k = 0; k < 2; k++)
         if (older[k].valid && older[k].rw && older[k].rd != 0 && older[k].rd == rs)
            return (k == 0) ? 2 : 1;
      return 0;
   endfunction

   task automatic chk(string nm, longint act, longint expv);
      checks++;
      if (act != expv) begin
         failures++;
         $display("FAIL %s t=%0t got=%0d expected=%0d", nm, $time, act, expv);
      end
   endtask

   task automatic model_reset();
      ex = nop(); mm = nop(); wb = nop();
      waitrun = 0; err_m = 0; sc_m = 0; fc_m = 0;
      last_sd = 0; last_mw = 0;
   endtask

   task automatic do_reset();
      exp_t e;
      rst = 1'b0; valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
      regwrite_d = 0; resultsrc_d = 0; memwrite_d = 0; pcsrc_e = 0; dmem_ready = 1;
      model_reset();
      e = '{default: 0};
      q.push_back(e);
      @(posedge clk); #1;
   endtask

   task automatic step(instr_t d, bit pc, bit rdy);
      exp_t e;
      bit   mw_c, lu;
      rst         = 1'b1;
      valid_d     = d.valid;
      rs1_d       = 5'(d.rs1);
      rs2_d       = 5'(d.rs2);
      rd_d        = 5'(d.rd);
      regwrite_d  = d.rw;
      resultsrc_d = d.ld ? 2'b01 : ((d.rd % 2 == 1) ? 2'b10 : 2'b00);
      memwrite_d  = d.mw;
      pcsrc_e     = pc;
      dmem_ready  = rdy;

      mw_c = mm.valid && (mm.ld || mm.mw) && !rdy;
      lu   = ex.valid && ex.rw && ex.ld && ex.rd != 0 && (ex.rd == d.rs1 || ex.rd == d.rs2);
      e     = '{default: 0};
      e.fa  = fwd(ex.rs1);
      e.fb  = fwd(ex.rs2);
      e.err = err_m;
      e.sc  = sc_m;
      e.fc  = fc_m;
      if (mw_c) begin
         e.sf = 1; e.sd = 1; e.se = 1; e.sm = 1; e.sw = 1;
      end else if (pc) begin
         e.fd = 1; e.fe = 1;
      end else if (lu) begin
         e.sf = 1; e.sd = 1; e.fe = 1;
      end
      q.push_back(e);

      if (!mw_c) begin
         wb = mm;
         mm = ex;
         ex = (pc || lu) ? nop() : d;
      end
      waitrun = mw_c ? waitrun + 1 : 0;
      if (waitrun >= TO) err_m = 1;
      if (e.sd) sc_m = sc_m + 1;
      if (e.fd) fc_m = fc_m + 1;
      last_sd = e.sd;
      last_mw = mw_c;
      @(posedge clk); #1;
   endtask

   // Monitor: one expected record per cycle, compared on the falling edge
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("stall_f", stall_f, e.sf);
            chk("stall_d", stall_d, e.sd);
            chk("stall_e", stall_e, e.se);
            chk("stall_m", stall_m, e.sm);
            chk("stall_w", stall_w, e.sw);
            chk("flush_d", flush_d, e.fd);
            chk("flush_e", flush_e, e.fe);
            chk("forward_a_e", forward_a_e, e.fa);
            chk("forward_b_e", forward_b_e, e.fb);
            chk("mem_err", mem_err, e.err);
`ifdef HAZ_PERF_CNT_EN
            chk("stall_cycles", stall_cycles, e.sc);
            chk("flush_count", flush_count, e.fc);
`endif
         end
      end
   end

   initial begin
      instr_t cur;
      bit     pc;
      rst = 1'b0; valid_d = 0; rs1_d = 0; rs2_d = 0; rd_d = 0;
      regwrite_d = 0; resultsrc_d = 0; memwrite_d = 0; pcsrc_e = 0; dmem_ready = 1;
      @(posedge clk); #1;
      do_reset();
      do_reset();

      // ALU producer followed by two readers: MEM then WB forwarding
      step(mk(1, 5, 1, 2, 1, 0, 0), 0, 1);
      step(mk(1, 7, 5, 0, 1, 0, 0), 0, 1);
      step(mk(1, 9, 5, 5, 1, 0, 0), 0, 1);
      repeat (3) step(nop(), 0, 1);

      // Load-use: reader held in decode for the bubble cycle
      step(mk(1, 6, 0, 0, 1, 1, 0), 0, 1);
      step(mk(1, 3, 6, 1, 1, 0, 0), 0, 1);
      step(mk(1, 3, 6, 1, 1, 0, 0), 0, 1);
      repeat (3) step(nop(), 0, 1);

      // Load-use coinciding with a redirect
      step(mk(1, 7, 0, 0, 1, 1, 0), 0, 1);
      step(mk(1, 2, 1, 7, 1, 0, 0), 1, 1);
      repeat (3) step(nop(), 0, 1);

      // Short memory wait of three cycles
      step(mk(1, 8, 0, 0, 1, 1, 0), 0, 1);
      step(mk(1, 2, 8, 0, 1, 0, 0), 0, 1);
      step(mk(1, 2, 8, 0, 1, 0, 0), 0, 0);
      repeat (2) step(mk(1, 2, 8, 0, 1, 0, 0), 0, 0);
      repeat (3) step(nop(), 0, 1);

      // x0 producers never forward or stall
      step(mk(1, 0, 1, 2, 1, 0, 0), 0, 1);
      step(mk(1, 3, 0, 0, 1, 0, 0), 0, 1);
      step(mk(1, 0, 1, 1, 1, 1, 0), 0, 1);
      step(mk(1, 3, 0, 0, 1, 0, 0), 0, 1);
      repeat (3) step(nop(), 0, 1);

      // Randomised traffic; decode holds while stalled, redirect held while frozen
      cur = rnd();
      pc  = 0;
      for (int n = 0; n < 1500; n++) begin
         if (!last_mw) pc = ex.valid && ($urandom_range(0, 7) == 0);
         step(cur, pc, $urandom_range(0, 4) != 0);
         if (!last_sd) cur = rnd();
      end

      // Long wait: timeout flag rises and sticks
      do_reset();
      step(mk(1, 9, 0, 0, 1, 1, 0), 0, 1);
      step(nop(), 0, 1);
      repeat (20) step(nop(), 0, 0);
      repeat (4) step(nop(), 0, 1);

      // Reset in the middle of a wait clears everything
      step(mk(1, 10, 0, 0, 0, 0, 1), 0, 1);
      step(nop(), 0, 1);
      repeat (5) step(nop(), 0, 0);
      do_reset();
      repeat (3) step(nop(), 0, 0);
      step(mk(1, 4, 0, 0, 1, 0, 0), 0, 1);
      repeat (3) step(mk(1, 5, 4, 4, 1, 0, 0), 0, 1);

      @(negedge clk); #1;
      chk("queue_drained", q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
